// File: rtl/bin2bcd_seq_dd.sv
// bin2bcd_seq_dd: iterative double-dabble converter. It turns a binary word into packed BCD,
// doing one shift-add-3 step per clock behind a start/busy/done handshake.
// Optional feature macro: SIGNED_INPUT_EN. When defined, bin_in is two's complement and
// sign_out carries the sign. When undefined, bin_in is unsigned and sign_out stays 0.
module bin2bcd_seq_dd #(
   parameter int unsigned W      = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [W-1:0]          bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  sign_out
);

   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(W + 1);

   // True when DIGITS decimal digits can hold the largest W-bit magnitude.
   function automatic bit f_digits_ok();
      logic [255:0] p;
      p = 256'd1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         p = p * 256'd10;
      end
      return p > ((256'd1 << W) - 256'd1);
   endfunction

   if (W < 2) begin : g_chk_w
      $error("bin2bcd_seq_dd: W must be >= 2");
   end
   if (!f_digits_ok()) begin : g_chk_digits
      $error("bin2bcd_seq_dd: DIGITS too small for W");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [W-1:0]      r_shreg, w_shreg_nxt;
   logic [BW-1:0]     r_scr, w_scr_nxt;
   logic [CW-1:0]     r_cnt, w_cnt_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;
   logic [BW-1:0]     r_bcd, w_bcd_nxt;
   logic              r_sign, w_sign_nxt;
   logic              r_sgn_lat, w_sgn_lat_nxt;

   logic [BW-1:0]     w_adj;
   logic [BW+W-1:0]   w_cat;
   logic [W-1:0]      w_operand;
   logic              w_sign_in;

`ifdef SIGNED_INPUT_EN
   // The magnitude of a two's-complement operand. The most negative value maps to 2**(W-1).
   assign w_sign_in = bin_in[W-1];
   assign w_operand = w_sign_in ? ((~bin_in) + W'(1)) : bin_in;
`else
   // Unsigned operand is used as-is and carries no sign.
   assign w_sign_in = 1'b0;
   assign w_operand = bin_in;
`endif

   // Add 3 to each scratch digit that is >= 5. Each nibble is adjusted on its own,
   // with no carry between digits.
   always_comb begin
      w_adj = r_scr;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (r_scr[4*d +: 4] >= 4'd5) begin
            w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
         end
      end
   end

   // Shift the adjusted scratch and the operand together by one bit.
   assign w_cat = {w_adj, r_shreg} << 1;

   // Next-state and next-register logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_shreg_nxt   = r_shreg;
      w_scr_nxt     = r_scr;
      w_cnt_nxt     = r_cnt;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_bcd_nxt     = r_bcd;
      w_sign_nxt    = r_sign;
      w_sgn_lat_nxt = r_sgn_lat;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_shreg_nxt   = w_operand;
               w_scr_nxt     = '0;
               w_cnt_nxt     = CW'(W);
               w_busy_nxt    = 1'b1;
               w_sgn_lat_nxt = w_sign_in;
               w_state_nxt   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_scr_nxt   = w_cat[BW+W-1:W];
            w_shreg_nxt = w_cat[W-1:0];
            w_cnt_nxt   = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_bcd_nxt   = r_scr;
            w_sign_nxt  = r_sgn_lat;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_shreg   <= '0;
         r_scr     <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_bcd     <= '0;
         r_sign    <= 1'b0;
         r_sgn_lat <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shreg   <= w_shreg_nxt;
         r_scr     <= w_scr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_bcd     <= w_bcd_nxt;
         r_sign    <= w_sign_nxt;
         r_sgn_lat <= w_sgn_lat_nxt;
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign bcd_out  = r_bcd;
   assign sign_out = r_sign;

endmodule
